// File: rtl/stream_downsizer.sv
// Valid/ready width reducer: each WIDTH-bit word leaves as RATIO slices, least-significant slice first.
// Optional per-slice keep mask is enabled with STREAM_DOWNSIZER_KEEP_EN.
module stream_downsizer #(
  parameter int WIDTH = 32,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_vld,
  output logic                   o_rdy,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_last,
`ifdef STREAM_DOWNSIZER_KEEP_EN
  input  logic [RATIO-1:0]       i_keep,
`endif
  output logic                   o_vld,
  input  logic                   i_rdy,
  output logic [WIDTH/RATIO-1:0] o_data,
  output logic                   o_last
);

  localparam int SW = WIDTH / RATIO;
  localparam int IW = $clog2(RATIO);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             lf_q, lf_d;

  logic [WIDTH-1:0] sh_adv, sh_load;
  logic [IW-1:0]    idx_adv, idx_load, fin_idx;
  logic             busy, is_final, accept, xfer, load_busy;

`ifdef STREAM_DOWNSIZER_KEEP_EN
  logic [RATIO-1:0] keep_q, keep_d;

  // Skipped slices are jumped over by shifting several slices at once.
  always_comb begin
    fin_idx  = '0;
    idx_adv  = idx_q;
    idx_load = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (keep_q[k]) fin_idx = IW'(k);
    end
    for (int k = RATIO - 1; k >= 0; k--) begin
      if (keep_q[k] && k > int'(idx_q)) idx_adv = IW'(k);
      if (i_keep[k]) idx_load = IW'(k);
    end
    sh_adv    = sh_q >> (SW * (int'(idx_adv) - int'(idx_q)));
    sh_load   = i_data >> (SW * int'(idx_load));
    load_busy = |i_keep;
  end
`else
  assign fin_idx   = IW'(RATIO - 1);
  assign idx_adv   = idx_q + 1'b1;
  assign idx_load  = '0;
  assign sh_adv    = sh_q >> SW;
  assign sh_load   = i_data;
  assign load_busy = 1'b1;
`endif

  assign busy     = (state_q == BUSY);
  assign is_final = (idx_q == fin_idx);
  assign o_vld    = busy;
  assign o_data   = sh_q[SW-1:0];
  assign o_last   = busy && lf_q && is_final;
  assign o_rdy    = !busy || (i_rdy && is_final);
  assign accept   = i_vld && o_rdy;
  assign xfer     = o_vld && i_rdy;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    lf_d    = lf_q;
`ifdef STREAM_DOWNSIZER_KEEP_EN
    keep_d  = keep_q;
`endif
    if (xfer) begin
      if (is_final) begin
        state_d = IDLE;
      end else begin
        sh_d  = sh_adv;
        idx_d = idx_adv;
      end
    end
    // A new word overrides the final-slice retirement in the same cycle.
    if (accept) begin
      sh_d    = sh_load;
      idx_d   = idx_load;
      lf_d    = i_last;
      state_d = load_busy ? BUSY : IDLE;
`ifdef STREAM_DOWNSIZER_KEEP_EN
      keep_d  = i_keep;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      lf_q    <= 1'b0;
`ifdef STREAM_DOWNSIZER_KEEP_EN
      keep_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      lf_q    <= lf_d;
`ifdef STREAM_DOWNSIZER_KEEP_EN
      keep_q  <= keep_d;
`endif
    end
  end

endmodule

// File: tb/tb_stream_downsizer.sv
// Directed bench for stream_downsizer (WIDTH=32, RATIO=4); keep-mask cases build with STREAM_DOWNSIZER_KEEP_EN.
module tb_stream_downsizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_vld;
  logic        o_rdy;
  logic [31:0] i_data;
  logic        i_last;
`ifdef STREAM_DOWNSIZER_KEEP_EN
  logic [3:0]  i_keep;
`endif
  logic        o_vld;
  logic        i_rdy;
  logic [7:0]  o_data;
  logic        o_last;

  int n_chk  = 0;
  int n_pass = 0;

  stream_downsizer #(.WIDTH(32), .RATIO(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (i_vld),
    .o_rdy  (o_rdy),
    .i_data (i_data),
    .i_last (i_last),
`ifdef STREAM_DOWNSIZER_KEEP_EN
    .i_keep (i_keep),
`endif
    .o_vld  (o_vld),
    .i_rdy  (i_rdy),
    .o_data (o_data),
    .o_last (o_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got=%0h", tag, got);
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] s1 [4];
    logic [7:0] s2 [8];
    int e;
    s1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    s2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    rst_n  = 1'b0;
    i_vld  = 1'b0;
    i_data = '0;
    i_last = 1'b0;
    i_rdy  = 1'b0;
`ifdef STREAM_DOWNSIZER_KEEP_EN
    i_keep = 4'hF;
`endif
    #1;
    chk("rst_o_vld", 32'(o_vld), 0);
    chk("rst_o_rdy", 32'(o_rdy), 1);
    chk("rst_o_last", 32'(o_last), 0);
    chk("rst_o_data", 32'(o_data), 0);
    #12 rst_n = 1'b1;
    step();

    // Single word, downstream always ready.
    i_vld = 1'b1; i_data = 32'hDDCCBBAA; i_last = 1'b1; i_rdy = 1'b1;
    step();
    i_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("w1_data%0d", k), 32'(o_data), 32'(s1[k]));
      chk($sformatf("w1_vld%0d", k), 32'(o_vld), 1);
      chk($sformatf("w1_last%0d", k), 32'(o_last), (k == 3) ? 1 : 0);
      step();
    end
    chk("w1_idle_vld", 32'(o_vld), 0);

    // Two words back to back, no gap between them.
    i_vld = 1'b1; i_data = 32'h44332211; i_last = 1'b0;
    step();
    i_data = 32'h88776655; i_last = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b2b_data%0d", k), 32'(o_data), 32'(s2[k]));
      chk($sformatf("b2b_vld%0d", k), 32'(o_vld), 1);
      chk($sformatf("b2b_rdy%0d", k), 32'(o_rdy), (k == 3 || k == 7) ? 1 : 0);
      chk($sformatf("b2b_last%0d", k), 32'(o_last), (k == 7) ? 1 : 0);
      step();
      if (k == 3) i_vld = 1'b0;
    end
    chk("b2b_idle_vld", 32'(o_vld), 0);
    chk("b2b_idle_rdy", 32'(o_rdy), 1);

    // Backpressure: i_rdy high one cycle in three.
    i_vld = 1'b1; i_data = 32'hDDCCBBAA; i_last = 1'b1; i_rdy = 1'b1;
    step();
    i_vld = 1'b0;
    e = 0;
    for (int cyc = 0; cyc < 20 && e < 4; cyc++) begin
      i_rdy = (cyc % 3 == 0);
      chk($sformatf("bp_data_c%0d", cyc), 32'(o_data), 32'(s1[e]));
      chk($sformatf("bp_vld_c%0d", cyc), 32'(o_vld), 1);
      chk($sformatf("bp_last_c%0d", cyc), 32'(o_last), (e == 3) ? 1 : 0);
      step();
      if (i_rdy) e++;
    end
    chk("bp_slices_done", 32'(e), 4);
    chk("bp_idle_vld", 32'(o_vld), 0);

    // Asynchronous reset mid-word after AA and BB have left.
    i_rdy = 1'b1; i_vld = 1'b1; i_data = 32'hDDCCBBAA; i_last = 1'b1;
    step();
    i_vld = 1'b0;
    step();
    chk("mid_bb", 32'(o_data), 32'hBB);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(o_vld), 0);
    chk("arst_last", 32'(o_last), 0);
    chk("arst_rdy", 32'(o_rdy), 1);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post_rst_vld%0d", k), 32'(o_vld), 0);
    end

`ifdef STREAM_DOWNSIZER_KEEP_EN
    // Sparse keep: AA then CC, next word loads during CC.
    i_vld = 1'b1; i_data = 32'hDDCCBBAA; i_last = 1'b1; i_keep = 4'b0101;
    step();
    i_data = 32'h04030201; i_keep = 4'hF; i_last = 1'b0;
    chk("keep_aa", 32'(o_data), 32'hAA);
    chk("keep_aa_rdy", 32'(o_rdy), 0);
    chk("keep_aa_last", 32'(o_last), 0);
    step();
    chk("keep_cc", 32'(o_data), 32'hCC);
    chk("keep_cc_last", 32'(o_last), 1);
    chk("keep_cc_rdy", 32'(o_rdy), 1);
    step();
    i_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("keep_nxt%0d", k), 32'(o_data), 32'(k + 1));
      step();
    end
    chk("keep_nxt_idle", 32'(o_vld), 0);

    // Empty keep mask is swallowed.
    i_vld = 1'b1; i_data = 32'hDEADBEEF; i_last = 1'b1; i_keep = 4'h0;
    step();
    chk("keep0_vld", 32'(o_vld), 0);
    chk("keep0_last", 32'(o_last), 0);
    i_data = 32'h04030201; i_keep = 4'hF;
    step();
    i_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("keep0_nxt%0d", k), 32'(o_data), 32'(k + 1));
      chk($sformatf("keep0_last%0d", k), 32'(o_last), (k == 3) ? 1 : 0);
      step();
    end
    chk("keep0_idle", 32'(o_vld), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
